// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes and
// the bit positions of the Status and Cause fields.
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // Exception codes carried in Cause.ExcCode
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Status field positions
    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 8;

    // Cause field positions
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 8;
    localparam int CAUSE_TI      = 15;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: a prescaler divides clk by TIMER_DIV to
// advance Count; a sticky pending flag is raised when an increment
// lands on Compare and is cleared by any Compare write.
module cp0_timer #(
    parameter int TIMER_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        pending
);

    localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    logic [PW-1:0] presc;
    logic          tick;
    logic [31:0]   count_next;

    // Prescaler wrap marks the cycle Count advances
    always_comb begin
        tick       = (presc == PW'(TIMER_DIV - 1));
        count_next = count + 32'd1;
    end

    // Prescaler, Count, Compare and the sticky match flag
    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            count   <= '0;
            compare <= '0;
            pending <= 1'b0;
        end else begin
            // A software Count write restarts the prescaler and skips the increment
            if (wr_count) begin
                count <= wdata;
                presc <= '0;
            end else if (tick) begin
                count <= count_next;
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end

            if (wr_compare)
                compare <= wdata;

            // Writing Compare acknowledges the timer, even against a same-cycle match
            if (wr_compare)
                pending <= 1'b0;
            else if (!wr_count && tick && (count_next == compare))
                pending <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_irq_timer.sv
// CP0 for the 54-instruction pipeline: Status, Cause, EPC, BadVAddr,
// Count/Compare timer and NUM_IRQ level-sensitive interrupt lines.
// Raises int_req when an unmasked interrupt is pending and supplies
// the trap-entry / eret target on exc_addr.
module cp0_irq_timer
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ    = 6,
    parameter int          TIMER_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'h00400004,
    parameter logic [31:0] STATUS_RST = 32'h0000FF01
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mfc0,
    input  logic               mtc0,
    input  logic               eret,
    input  logic               exception,
    input  logic [4:0]         cause,
    input  logic [4:0]         addr,
    input  logic [31:0]        wdata,
    input  logic [31:0]        pc,
    input  logic [31:0]        bad_vaddr,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [31:0]        rdata,
    output logic [31:0]        status,
    output logic [31:0]        exc_addr,
    output logic               int_req,
    output logic               timer_int
);

    logic [7:0]         im;
    logic               exl;
    logic               ie;
    logic [NUM_IRQ-1:0] ip_hw;
    logic [4:0]         exc_code;
    logic [31:0]        epc;
    logic [31:0]        badvaddr;
    logic [31:0]        count;
    logic [31:0]        compare;
    logic               pending;
    logic [31:0]        cause_reg;
    logic               wr_status;
    logic               wr_epc;

    cp0_timer #(
        .TIMER_DIV (TIMER_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .wr_count   (mtc0 && (addr == REG_COUNT)),
        .wr_compare (mtc0 && (addr == REG_COMPARE)),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .pending    (pending)
    );

    // Assemble architectural Status/Cause views and the interrupt request
    always_comb begin
        wr_status = mtc0 && (addr == REG_STATUS);
        wr_epc    = mtc0 && (addr == REG_EPC);

        status                          = '0;
        status[STATUS_IM_LSB +: 8]      = im;
        status[STATUS_EXL]              = exl;
        status[STATUS_IE]               = ie;

        cause_reg                       = '0;
        cause_reg[CAUSE_IP_LSB +: NUM_IRQ] = ip_hw;
        cause_reg[CAUSE_TI]             = pending;
        cause_reg[CAUSE_EXC_LSB +: 5]   = exc_code;

        timer_int = pending;
        int_req   = ie && !exl && (|(cause_reg[15:8] & im));
        exc_addr  = eret ? epc : EXC_VECTOR;
    end

    // Combinational register read port
    always_comb begin
        rdata = '0;
        if (mfc0) begin
            case (addr)
                REG_BADVADDR: rdata = badvaddr;
                REG_COUNT:    rdata = count;
                REG_COMPARE:  rdata = compare;
                REG_STATUS:   rdata = status;
                REG_CAUSE:    rdata = cause_reg;
                REG_EPC:      rdata = epc;
                default:      rdata = '0;
            endcase
        end
    end

    // Status/Cause/EPC/BadVAddr update; exception beats eret beats mtc0 on shared fields
    always_ff @(posedge clk) begin
        if (rst) begin
            im       <= STATUS_RST[15:8];
            exl      <= STATUS_RST[1];
            ie       <= STATUS_RST[0];
            ip_hw    <= '0;
            exc_code <= '0;
            epc      <= EXC_VECTOR;
            badvaddr <= '0;
        end else begin
            ip_hw <= irq;

            if (wr_status) begin
                im <= wdata[15:8];
                ie <= wdata[0];
            end

            if (exception)
                exl <= 1'b1;
            else if (eret)
                exl <= 1'b0;
            else if (wr_status)
                exl <= wdata[1];

            // A nested trap keeps the original return address
            if (exception) begin
                if (!exl)
                    epc <= pc;
            end else if (wr_epc) begin
                epc <= wdata;
            end

            if (exception) begin
                exc_code <= cause;
                if ((cause == EXC_ADEL) || (cause == EXC_ADES))
                    badvaddr <= bad_vaddr;
            end
        end
    end

endmodule

// File: tb/tb_cp0_irq_timer.sv
// Directed bench for cp0_irq_timer with hand-computed expectations.
module tb_cp0_irq_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mfc0;
    logic        mtc0;
    logic        eret;
    logic        exception;
    logic [4:0]  cause;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] bad_vaddr;
    logic [5:0]  irq;
    logic [31:0] rdata;
    logic [31:0] status;
    logic [31:0] exc_addr;
    logic        int_req;
    logic        timer_int;

    int total  = 0;
    int passed = 0;

    always #10 clk = ~clk;

    cp0_irq_timer #(
        .NUM_IRQ    (6),
        .TIMER_DIV  (2),
        .EXC_VECTOR (32'h00400004),
        .STATUS_RST (32'h0000FF01)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mfc0      (mfc0),
        .mtc0      (mtc0),
        .eret      (eret),
        .exception (exception),
        .cause     (cause),
        .addr      (addr),
        .wdata     (wdata),
        .pc        (pc),
        .bad_vaddr (bad_vaddr),
        .irq       (irq),
        .rdata     (rdata),
        .status    (status),
        .exc_addr  (exc_addr),
        .int_req   (int_req),
        .timer_int (timer_int)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        mfc0 = 1'b1;
        addr = a;
        #1;
        check(tag, rdata, exp);
        mfc0 = 1'b0;
        addr = 5'd0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        mtc0  = 1'b1;
        addr  = a;
        wdata = d;
        step();
        mtc0  = 1'b0;
        addr  = 5'd0;
        wdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1; mfc0 = 1'b0; mtc0 = 1'b0; eret = 1'b0; exception = 1'b0;
        cause = 5'd0; addr = 5'd0; wdata = 32'h0; pc = 32'h0; bad_vaddr = 32'h0; irq = 6'd0;

        // 1. reset
        step();
        rst = 1'b0;
        #1;
        check("rst_status", status, 32'h0000FF01);
        check("rst_rdata_idle", rdata, 32'h0);
        check("rst_int_req", {31'h0, int_req}, 32'h0);
        check("rst_timer_int", {31'h0, timer_int}, 32'h0);
        rd_check("rst_epc", 5'd14, 32'h00400004);
        rd_check("rst_count", 5'd9, 32'h0);
        rd_check("rst_cause", 5'd13, 32'h0);

        // 2. timer match at Count=5 (posedge 10 after reset release)
        wr(5'd11, 32'd5);
        repeat (8) step();
        check("tmr_before_match", {31'h0, timer_int}, 32'h0);
        rd_check("tmr_count_4", 5'd9, 32'd4);
        step();
        check("tmr_match", {31'h0, timer_int}, 32'h1);
        rd_check("tmr_count_5", 5'd9, 32'd5);
        check("tmr_int_req", {31'h0, int_req}, 32'h1);
        rd_check("tmr_cause_ip7", 5'd13, 32'h00008000);
        wr(5'd11, 32'd100);
        check("tmr_clear", {31'h0, timer_int}, 32'h0);
        check("tmr_clear_req", {31'h0, int_req}, 32'h0);

        // 3. hardware interrupt, trap entry, eret
        wr(5'd12, 32'h00000401);
        check("irq_status_wr", status, 32'h00000401);
        irq = 6'b000100;
        #1;
        check("irq_req_latency", {31'h0, int_req}, 32'h0);
        step();
        check("irq_req", {31'h0, int_req}, 32'h1);
        rd_check("irq_cause_ip", 5'd13, 32'h00000400);
        exception = 1'b1; cause = 5'd0; pc = 32'h00400100;
        step();
        exception = 1'b0;
        rd_check("trap_epc", 5'd14, 32'h00400100);
        check("trap_status_exl", status, 32'h00000403);
        check("trap_int_req_masked", {31'h0, int_req}, 32'h0);
        eret = 1'b1;
        #1;
        check("eret_exc_addr", exc_addr, 32'h00400100);
        step();
        eret = 1'b0;
        #1;
        check("eret_status", status, 32'h00000401);
        check("vector_exc_addr", exc_addr, 32'h00400004);
        irq = 6'd0;
        step();
        check("irq_drop", {31'h0, int_req}, 32'h0);

        // 4. nested exception keeps first EPC
        exception = 1'b1; cause = 5'd8; pc = 32'h00400200;
        step();
        cause = 5'd12; pc = 32'h00400300;
        step();
        exception = 1'b0;
        rd_check("nest_epc", 5'd14, 32'h00400200);
        rd_check("nest_cause", 5'd13, 32'h00000030);
        check("nest_status", status, 32'h00000403);
        eret = 1'b1;
        step();
        eret = 1'b0;

        // 5. address error with a same-cycle Status write
        exception = 1'b1; cause = 5'd4; bad_vaddr = 32'h00000003; pc = 32'h00400400;
        mtc0 = 1'b1; addr = 5'd12; wdata = 32'h0;
        step();
        exception = 1'b0; mtc0 = 1'b0; addr = 5'd0;
        check("adel_status", status, 32'h00000002);
        rd_check("adel_badvaddr", 5'd8, 32'h00000003);
        rd_check("adel_epc", 5'd14, 32'h00400400);
        rd_check("adel_cause", 5'd13, 32'h00000010);
        wr(5'd8, 32'h0000FFFF);
        rd_check("badvaddr_ro", 5'd8, 32'h00000003);
        wr(5'd3, 32'h12345678);
        rd_check("unmapped_reg", 5'd3, 32'h0);
        eret = 1'b1;
        step();
        eret = 1'b0;

        // Count writes: no match on written value, wrap mod 2^32
        wr(5'd9, 32'd100);
        check("cnt_wr_nomatch", {31'h0, timer_int}, 32'h0);
        wr(5'd9, 32'hFFFFFFFF);
        step();
        step();
        rd_check("cnt_wrap", 5'd9, 32'h0);

        // 6. reset while timer pending
        wr(5'd9, 32'd98);
        repeat (4) step();
        check("pre_rst_pending", {31'h0, timer_int}, 32'h1);
        rd_check("pre_rst_count", 5'd9, 32'd100);
        rst = 1'b1; exception = 1'b1; cause = 5'd12; pc = 32'h00400500;
        step();
        rst = 1'b0; exception = 1'b0;
        check("rst2_timer_int", {31'h0, timer_int}, 32'h0);
        check("rst2_status", status, 32'h0000FF01);
        rd_check("rst2_count", 5'd9, 32'h0);
        rd_check("rst2_epc", 5'd14, 32'h00400004);
        rd_check("rst2_cause", 5'd13, 32'h0);
        step();
        rd_check("rst2_count_hold", 5'd9, 32'h0);
        step();
        rd_check("rst2_count_run", 5'd9, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
